// File: rtl/rld_fifo_pkg.sv
// Shared constants, helpers and FSM encoding for the RLDRAM packet FIFO arbiters.
package rld_fifo_pkg;
  localparam int META_W           = 16;
  localparam int CTRL_W           = 6;
  localparam int CTRL_LSB         = 0;
  localparam int META_LSB         = CTRL_LSB + CTRL_W;
  localparam int DATA_LSB         = META_LSB + META_W;
  localparam int TDATA_WIDTH_DFLT = 32;

  // Packed word is {tdata, meta, ctrl}; tdata width is given in bytes.
  function automatic int word_w(input int tdata_bytes);
    return 8 * tdata_bytes + META_W + CTRL_W;
  endfunction

  localparam int WORD_W = word_w(TDATA_WIDTH_DFLT);

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);
  // Scan last+1, last+2, ... ; the IDW-bit add wraps because N is a power of two.
  always_comb begin
    logic [IDW-1:0] idx;
    idx        = '0;
    gnt_id     = '0;
    any        = 1'b0;
    gnt_onehot = '0;
    for (int i = 1; i <= N; i++) begin
      idx = last + IDW'(i);
      if (!any && req[idx]) begin
        gnt_id = idx;
        any    = 1'b1;
      end
    end
    if (any) gnt_onehot[gnt_id] = 1'b1;
  end
endmodule

// File: rtl/rld_fifo_wr_arbiter.sv
// Write-side arbiter: grants one eligible ingress queue round-robin and streams
// one BURST_LEN-word burst from it to the RLDRAM write path.
module rld_fifo_wr_arbiter
  import rld_fifo_pkg::*;
#(
  parameter int TDATA_WIDTH    = 32,
  parameter int NUM_QUEUES     = 4,
  parameter int QUEUE_ID_WIDTH = 2,
  parameter int BURST_LEN      = 4,
  localparam int WW            = word_w(TDATA_WIDTH)
) (
  input  logic                      memclk,
  input  logic                      reset,
  input  logic [NUM_QUEUES*WW-1:0]  in_data,
  input  logic [NUM_QUEUES-1:0]     in_burst_avail,
  output logic [NUM_QUEUES-1:0]     in_rd_en,
  input  logic [NUM_QUEUES-1:0]     mem_queue_full,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [WW-1:0]             wr_data,
  output logic [QUEUE_ID_WIDTH-1:0] wr_queue_id,
  output logic                      wr_first,
  output logic                      wr_last,
  output logic [NUM_QUEUES-1:0]     burst_done
);
  localparam int CNT_W = clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  arb_state_e                state_q;
  logic [NUM_QUEUES-1:0]     grant_oh_q;
  logic [QUEUE_ID_WIDTH-1:0] last_grant_q;
  logic [QUEUE_ID_WIDTH-1:0] wr_queue_id_q;
  logic [CNT_W-1:0]          issue_cnt_q;
  logic                      wr_valid_q, wr_first_q, wr_last_q;
  logic [WW-1:0]             wr_data_q;
  logic [NUM_QUEUES-1:0]     burst_done_q;

  logic [NUM_QUEUES-1:0]     elig, rr_oh;
  logic [QUEUE_ID_WIDTH-1:0] rr_id;
  logic                      rr_any, pop;

  assign elig = in_burst_avail & ~mem_queue_full;

  rr_arbiter #(.N(NUM_QUEUES), .IDW(QUEUE_ID_WIDTH)) u_rr (
    .req        (elig),
    .last       (last_grant_q),
    .gnt_onehot (rr_oh),
    .gnt_id     (rr_id),
    .any        (rr_any)
  );

  // Pop while words remain and the output register is empty or draining.
  assign pop      = (state_q == BURST) && (issue_cnt_q < CNT_MAX) && (!wr_valid_q || wr_ready);
  assign in_rd_en = reset ? '0 : ({NUM_QUEUES{pop}} & grant_oh_q);

  // Grant/burst FSM with registered write-beat outputs.
  always_ff @(posedge memclk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_oh_q    <= '0;
      last_grant_q  <= QUEUE_ID_WIDTH'(NUM_QUEUES - 1);
      wr_queue_id_q <= '0;
      issue_cnt_q   <= '0;
      wr_valid_q    <= 1'b0;
      wr_first_q    <= 1'b0;
      wr_last_q     <= 1'b0;
      wr_data_q     <= '0;
      burst_done_q  <= '0;
    end else begin
      burst_done_q <= '0;
      case (state_q)
        IDLE: begin
          if (rr_any) begin
            grant_oh_q    <= rr_oh;
            wr_queue_id_q <= rr_id;
            last_grant_q  <= rr_id;
            issue_cnt_q   <= '0;
            state_q       <= BURST;
          end
        end
        BURST: begin
          if (pop) begin
            wr_data_q   <= in_data[int'(wr_queue_id_q)*WW +: WW];
            wr_valid_q  <= 1'b1;
            wr_first_q  <= (issue_cnt_q == '0);
            wr_last_q   <= (issue_cnt_q == CNT_LAST);
            issue_cnt_q <= issue_cnt_q + CNT_W'(1);
          end else if (wr_valid_q && wr_ready) begin
            wr_valid_q <= 1'b0;
            if (wr_last_q) begin
              burst_done_q <= grant_oh_q;
              state_q      <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_valid    = wr_valid_q;
  assign wr_data     = wr_data_q;
  assign wr_queue_id = wr_queue_id_q;
  assign wr_first    = wr_first_q;
  assign wr_last     = wr_last_q;
  assign burst_done  = burst_done_q;
endmodule
